// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module   : serial_adder_ctrl (with half_adder leaf cell)
// Brief    : Bit-serial adder; one shared full-adder cell, LSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] opa, opb, res, res_next;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             s0, c0, s, c1, carry_d;

    half_adder ha0 (.a(opa[0]), .b(opb[0]),   .s(s0), .c(c0));
    half_adder ha1 (.a(s0),     .b(carry_q), .s(s),  .c(c1));
    assign carry_d = c0 | c1;

    // A one-bit result register has no upper bits to shift down.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = s;
        end else begin : g_res_wn
            assign res_next = {s, res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                opa     <= a;
                opb     <= b;
                carry_q <= 1'b0;
                cnt     <= '0;
            end
        end else if (state == RUN) begin
            res     <= res_next;
            opa     <= opa >> 1;
            opb     <= opb >> 1;
            carry_q <= carry_d;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST) begin
                sum       <= res_next;
                carry_out <= carry_d;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Brief    : Directed self-checking bench for WIDTH=8, 4 and 1 builds.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, start4 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy8, done8, cout8, busy4, done4, cout4, busy1, done1, cout1;
    logic [7:0] sum8;
    logic [3:0] sum4;
    logic [0:0] sum1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8));
    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; optionally scrambles a/b while running.
    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] es, input logic ec, input bit scramble);
        a8 = x; b8 = y; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("run8_busy", busy8, 1'b1);
            check("run8_nodone", done8, 1'b0);
            if (scramble) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            tick();
        end
        check("run8_done", done8, 1'b1);
        check("run8_busy_low", busy8, 1'b0);
        check("run8_sum", sum8, es);
        check("run8_cout", cout8, ec);
        tick();
        check("run8_done_pulse", done8, 1'b0);
        check("run8_sum_hold", sum8, es);
    endtask

    initial begin
        logic [4:0] exp4;

        // Reset with start asserted: nothing may enter RUN.
        start8 = 1'b1; start4 = 1'b1; start1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_busy8", busy8, 1'b0);
            check("rst_busy4", busy4, 1'b0);
            check("rst_busy1", busy1, 1'b0);
        end
        check("rst_done8", done8, 1'b0);
        check("rst_sum8", sum8, 8'h00);
        check("rst_cout8", cout8, 1'b0);
        start8 = 1'b0; start4 = 1'b0; start1 = 1'b0;
        rst = 1'b0;
        tick();

        run8(8'h5A, 8'hA5, 8'hFF, 1'b0, 1'b0);
        run8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run8(8'h80, 8'h80, 8'h00, 1'b1, 1'b0);
        run8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run8(8'hC3, 8'h5E, 8'h21, 1'b1, 1'b1);

        // Start held: accepts every 10 cycles, done at offset 8 of each.
        a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
        tick();
        for (int k = 1; k <= 30; k++) begin
            tick();
            check("held_done", done8, (k % 10) == 8);
            if (k % 10 == 8) check("held_sum", sum8, 8'h10);
        end
        start8 = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("held_idle", busy8, 1'b0);

        // Mid-operation reset aborts without a done pulse.
        a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("abort_busy", busy8, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy_low", busy8, 1'b0);
        check("abort_sum", sum8, 8'h00);
        check("abort_cout", cout8, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("abort_nodone", done8, 1'b0);
        end
        run8(8'h33, 8'h44, 8'h77, 1'b0, 1'b0);

        // WIDTH=4 exhaustive.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
                tick();
                start4 = 1'b0;
                for (int k = 0; k < 4; k++) tick();
                exp4 = 5'(x + y);
                check("w4_done", done4, 1'b1);
                check("w4_result", {cout4, sum4}, exp4);
                tick();
            end
        end

        // WIDTH=1: 1+1 completes one cycle after accept.
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_busy", busy1, 1'b1);
        tick();
        check("w1_done", done1, 1'b1);
        check("w1_sum", sum1, 1'b0);
        check("w1_cout", cout1, 1'b1);
        tick();
        check("w1_done_pulse", done1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
